// File: rtl/layer_compositor.sv
// Registered N-layer pixel compositor: transparency-keyed priority mux with a
// frame-synchronous enable mask, blinking indicator squares and 2-cycle timing alignment.
module layer_compositor #(
  parameter int                          NUM_LAYERS   = 16,
  parameter int                          COLOR_W      = 12,
  parameter logic [COLOR_W-1:0]          KEY_COLOR    = 12'hFFF,
  parameter logic [COLOR_W-1:0]          BG_COLOR     = 12'hFFF,
  parameter int                          NUM_IND      = 4,
  parameter int                          IND_X0       = 640,
  parameter int                          IND_PITCH    = 50,
  parameter int                          IND_Y        = 50,
  parameter int                          IND_SIZE     = 20,
  parameter logic [NUM_IND*COLOR_W-1:0]  IND_COLORS   = {12'h0FF, 12'hF0F, 12'hFF0, 12'hF00},
  parameter int                          BLINK_FRAMES = 30
) (
  input  logic                               ClkPort,
  input  logic                               Reset,
  input  logic [NUM_LAYERS*COLOR_W-1:0]      layer_rgb,
  input  logic [NUM_LAYERS-1:0]              layer_en_req,
  input  logic                               layer_en_wr,
  input  logic [NUM_IND-1:0]                 ind_on,
  input  logic [NUM_IND-1:0]                 ind_blink,
  input  logic [9:0]                         hc,
  input  logic [9:0]                         vc,
  input  logic                               hSync_in,
  input  logic                               vSync_in,
  input  logic                               bright_in,
  output logic                               hSync,
  output logic                               vSync,
  output logic                               bright,
  output logic [3:0]                         vgaR,
  output logic [3:0]                         vgaG,
  output logic [3:0]                         vgaB,
  output logic [NUM_LAYERS-1:0]              layer_en,
  output logic [$clog2(NUM_LAYERS+1)-1:0]    hit_layer
);

  localparam int HW  = $clog2(NUM_LAYERS + 1);
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb;
  logic [9:0]                    s1_hc, s1_vc;
  logic                          s1_bright, s1_hsync, s1_vsync;
  logic [COLOR_W-1:0]            s2_pix;
  logic [NUM_LAYERS-1:0]         en_shadow;
  logic [FCW-1:0]                frame_cnt;
  logic                          blink_phase;
  logic                          frame_start;
  logic [COLOR_W-1:0]            res_pix;
  logic [HW-1:0]                 res_hit;

  // s1_vsync doubles as the previous-cycle copy of vSync_in for edge detection
  assign frame_start = s1_vsync & ~vSync_in;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      s1_rgb      <= '0;
      s1_hc       <= '0;
      s1_vc       <= '0;
      s1_bright   <= 1'b0;
      s1_hsync    <= 1'b1;
      s1_vsync    <= 1'b1;
      s2_pix      <= '0;
      hit_layer   <= HW'(NUM_LAYERS);
      hSync       <= 1'b1;
      vSync       <= 1'b1;
      bright      <= 1'b0;
      en_shadow   <= '1;
      layer_en    <= '1;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      s1_rgb    <= layer_rgb;
      s1_hc     <= hc;
      s1_vc     <= vc;
      s1_bright <= bright_in;
      s1_hsync  <= hSync_in;
      s1_vsync  <= vSync_in;
      s2_pix    <= res_pix;
      hit_layer <= res_hit;
      hSync     <= s1_hsync;
      vSync     <= s1_vsync;
      bright    <= s1_bright;
      if (layer_en_wr)
        en_shadow <= layer_en_req;
      if (frame_start) begin
        layer_en <= layer_en_wr ? layer_en_req : en_shadow;
        if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FCW'(1);
        end
      end
    end
  end

  // Ascending loops let the highest index win; indicators override layers, blanking overrides all
  always_comb begin
    logic               ind_hit;
    logic [COLOR_W-1:0] ind_col;
    logic [10:0]        x11, y11;
    res_pix = BG_COLOR;
    res_hit = HW'(NUM_LAYERS);
    ind_hit = 1'b0;
    ind_col = '0;
    x11     = {1'b0, s1_hc};
    y11     = {1'b0, s1_vc};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_en[i] && (s1_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR)) begin
        res_pix = s1_rgb[i*COLOR_W +: COLOR_W];
        res_hit = HW'(i);
      end
    end
    for (int i = 0; i < NUM_IND; i++) begin
      if (ind_on[i] && (!ind_blink[i] || blink_phase) &&
          (x11 >= 11'(IND_X0 + i*IND_PITCH)) && (x11 < 11'(IND_X0 + i*IND_PITCH + IND_SIZE)) &&
          (y11 >= 11'(IND_Y)) && (y11 < 11'(IND_Y + IND_SIZE))) begin
        ind_hit = 1'b1;
        ind_col = IND_COLORS[i*COLOR_W +: COLOR_W];
      end
    end
    if (ind_hit) begin
      res_pix = ind_col;
      res_hit = HW'(NUM_LAYERS);
    end
    if (!s1_bright) begin
      res_pix = '0;
      res_hit = HW'(NUM_LAYERS);
    end
  end

  assign vgaR = s2_pix[COLOR_W-1 -: 4];
  assign vgaG = s2_pix[COLOR_W-5 -: 4];
  assign vgaB = s2_pix[COLOR_W-9 -: 4];

endmodule
